// File: rtl/id_ex_hazard_reg.sv
// ID/EX pipeline register with valid bit, hold, flush, load-use bubble insertion
// and saturating bubble/flush event counters.
module id_ex_hazard_reg #(
    parameter int DATA_W  = 32,
    parameter int REG_W   = 5,
    parameter int ALUOP_W = 3,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rstN,
    input  logic [DATA_W-1:0]  pcAdded,
    input  logic [DATA_W-1:0]  read1,
    input  logic [DATA_W-1:0]  read2,
    input  logic [DATA_W-1:0]  imm,
    input  logic [REG_W-1:0]   rs,
    input  logic [REG_W-1:0]   rt,
    input  logic [REG_W-1:0]   rd,
    input  logic               idValid,
    input  logic               regDst,
    input  logic               aluSrc,
    input  logic               branch,
    input  logic               memWrite,
    input  logic               memRead,
    input  logic               regWrite,
    input  logic               memToReg,
    input  logic [ALUOP_W-1:0] aluOp,
    input  logic               hold,
    input  logic               flush,
    output logic [DATA_W-1:0]  outPcAdded,
    output logic [DATA_W-1:0]  outRead1,
    output logic [DATA_W-1:0]  outRead2,
    output logic [DATA_W-1:0]  outImm,
    output logic [REG_W-1:0]   outRs,
    output logic [REG_W-1:0]   outRt,
    output logic [REG_W-1:0]   outRd,
    output logic               outRegDst,
    output logic               outAluSrc,
    output logic               outBranch,
    output logic               outMemWrite,
    output logic               outMemRead,
    output logic               outRegWrite,
    output logic               outMemToReg,
    output logic [ALUOP_W-1:0] outAluOp,
    output logic               outValid,
    output logic               stallOut,
    output logic [CNT_W-1:0]   bubbleCount,
    output logic [CNT_W-1:0]   flushCount
);

    logic [DATA_W-1:0]  r_pc_added;
    logic [DATA_W-1:0]  r_read1;
    logic [DATA_W-1:0]  r_read2;
    logic [DATA_W-1:0]  r_imm;
    logic [REG_W-1:0]   r_rs;
    logic [REG_W-1:0]   r_rt;
    logic [REG_W-1:0]   r_rd;
    logic               r_reg_dst;
    logic               r_alu_src;
    logic               r_branch;
    logic               r_mem_write;
    logic               r_mem_read;
    logic               r_reg_write;
    logic               r_mem_to_reg;
    logic [ALUOP_W-1:0] r_alu_op;
    logic               r_valid;
    logic [CNT_W-1:0]   r_bubble_cnt;
    logic [CNT_W-1:0]   r_flush_cnt;

    logic               w_rt_hit;
    logic               w_load_use;
    logic               w_bubble;
    logic               w_ctl_en;

    // A load targeting $0 never creates a real dependency.
    assign w_rt_hit   = (r_rt == rs) || (r_rt == rt);
    assign w_load_use = r_valid && r_mem_read && (r_rt != '0) && idValid && w_rt_hit;
    assign w_bubble   = w_load_use && !flush && !hold;
    assign stallOut   = w_bubble;
    assign w_ctl_en   = idValid;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_pc_added   <= '0;
            r_read1      <= '0;
            r_read2      <= '0;
            r_imm        <= '0;
            r_rs         <= '0;
            r_rt         <= '0;
            r_rd         <= '0;
            r_reg_dst    <= 1'b0;
            r_alu_src    <= 1'b0;
            r_branch     <= 1'b0;
            r_mem_write  <= 1'b0;
            r_mem_read   <= 1'b0;
            r_reg_write  <= 1'b0;
            r_mem_to_reg <= 1'b0;
            r_alu_op     <= '0;
            r_valid      <= 1'b0;
        end else if (flush || (!hold && w_load_use)) begin
            // Flush and bubble both present a fully zeroed, invalid slot to EX.
            r_pc_added   <= '0;
            r_read1      <= '0;
            r_read2      <= '0;
            r_imm        <= '0;
            r_rs         <= '0;
            r_rt         <= '0;
            r_rd         <= '0;
            r_reg_dst    <= 1'b0;
            r_alu_src    <= 1'b0;
            r_branch     <= 1'b0;
            r_mem_write  <= 1'b0;
            r_mem_read   <= 1'b0;
            r_reg_write  <= 1'b0;
            r_mem_to_reg <= 1'b0;
            r_alu_op     <= '0;
            r_valid      <= 1'b0;
        end else if (!hold) begin
            r_pc_added   <= pcAdded;
            r_read1      <= read1;
            r_read2      <= read2;
            r_imm        <= imm;
            r_rs         <= rs;
            r_rt         <= rt;
            r_rd         <= rd;
            r_reg_dst    <= regDst   && w_ctl_en;
            r_alu_src    <= aluSrc   && w_ctl_en;
            r_branch     <= branch   && w_ctl_en;
            r_mem_write  <= memWrite && w_ctl_en;
            r_mem_read   <= memRead  && w_ctl_en;
            r_reg_write  <= regWrite && w_ctl_en;
            r_mem_to_reg <= memToReg && w_ctl_en;
            r_alu_op     <= w_ctl_en ? aluOp : '0;
            r_valid      <= idValid;
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_bubble_cnt <= '0;
            r_flush_cnt  <= '0;
        end else if (flush) begin
            if (!(&r_flush_cnt)) begin
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
            end
        end else if (w_bubble) begin
            if (!(&r_bubble_cnt)) begin
                r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
            end
        end
    end

    assign outPcAdded  = r_pc_added;
    assign outRead1    = r_read1;
    assign outRead2    = r_read2;
    assign outImm      = r_imm;
    assign outRs       = r_rs;
    assign outRt       = r_rt;
    assign outRd       = r_rd;
    assign outRegDst   = r_reg_dst;
    assign outAluSrc   = r_alu_src;
    assign outBranch   = r_branch;
    assign outMemWrite = r_mem_write;
    assign outMemRead  = r_mem_read;
    assign outRegWrite = r_reg_write;
    assign outMemToReg = r_mem_to_reg;
    assign outAluOp    = r_alu_op;
    assign outValid    = r_valid;
    assign bubbleCount = r_bubble_cnt;
    assign flushCount  = r_flush_cnt;

endmodule
